// File: rtl/bru_pkg.sv
// Shared types and constants for the branch resolve unit.
// Combinational definitions only; no latency.
// No flow control lives here.
package bru_pkg;

    localparam int BRU_PC_W = 10;
    localparam int BRU_XLEN = 32;

    // Conditional-branch funct3 encodings; 010/011 are reserved and never taken.
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // One pipeline slot: the IF prediction plus the ID decode that joins it in EXE.
    typedef struct packed {
        logic                vld;
        logic [BRU_PC_W-1:0] pc;
        logic                pred;
        logic [BRU_PC_W-1:0] pbt;
        logic                btype;
        logic                jump;
        logic                comp;
        logic [BRU_PC_W-1:0] target;
    } stage_t;

endpackage

// File: rtl/branch_cmp.sv
// Conditional-branch comparator: funct3 selects the relation between rs1 and rs2.
// Purely combinational, zero latency.
// No backpressure; output follows the operands.
module branch_cmp
    import bru_pkg::*;
#(
    parameter int XLEN = BRU_XLEN
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            taken
);

    // Evaluate the branch relation; unknown funct3 codes never branch.
    always_comb begin
        taken = 1'b0;
        case (funct3)
            F3_BEQ:  taken = (rs1 == rs2);
            F3_BNE:  taken = (rs1 != rs2);
            F3_BLT:  taken = ($signed(rs1) <  $signed(rs2));
            F3_BGE:  taken = ($signed(rs1) >= $signed(rs2));
            F3_BLTU: taken = (rs1 <  rs2);
            F3_BGEU: taken = (rs1 >= rs2);
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Carries IF predictions through ID into EXE, resolves the real outcome, feeds the BHT and flushes on mispredict.
// Two register stages (ID, EXE); results are combinational in the final EXE cycle of each instruction.
// id_stall/exe_stall hold their stage; a flush clears both valid bits. Optional BRU_PERF_CNT_EN adds saturating counters.
module branch_resolve_unit
    import bru_pkg::*;
#(
    parameter int PC_W  = BRU_PC_W,  // must match the stage_t layout in bru_pkg
    parameter int XLEN  = BRU_XLEN,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             nrst,
    input  logic             if_valid,
    input  logic [PC_W-1:0]  if_PC,
    input  logic             if_prediction,
    input  logic [PC_W-1:0]  if_PBT,
    input  logic             id_stall,
    input  logic             exe_stall,
    input  logic             id_is_btype,
    input  logic             id_is_jump,
    input  logic             id_is_comp,
    input  logic [PC_W-1:0]  id_branchtarget,
    input  logic [2:0]       exe_funct3,
    input  logic [XLEN-1:0]  exe_rs1,
    input  logic [XLEN-1:0]  exe_rs2,
    output logic [PC_W-1:0]  exe_PC,
    output logic             exe_update,
    output logic             exe_feedback,
    output logic             exe_correction,
    output logic             flush,
    output logic [PC_W-1:0]  exe_CNI,
    output logic [CNT_W-1:0] perf_br_cnt,
    output logic [CNT_W-1:0] perf_mp_cnt
);

    stage_t id_q, id_d, exe_q, exe_d;

    logic            cmp_taken;
    logic            taken;
    logic            resolve;
    logic            mispredict;
    logic [PC_W-1:0] fall;
    logic [PC_W-1:0] actual_next;
    logic [PC_W-1:0] pred_next;

    branch_cmp #(.XLEN(XLEN)) u_cmp (
        .funct3 (exe_funct3),
        .rs1    (exe_rs1),
        .rs2    (exe_rs2),
        .taken  (cmp_taken)
    );

    // Resolve the EXE instruction: reset suppresses it, a stalled one waits for its last cycle.
    always_comb begin
        resolve     = exe_q.vld & ~exe_stall & ~nrst;
        fall        = exe_q.pc + (exe_q.comp ? PC_W'(1) : PC_W'(2));
        taken       = exe_q.jump | (exe_q.btype & cmp_taken);
        actual_next = taken ? exe_q.target : fall;
        // A predicted-taken non-branch (BHT alias) lands here too: its pred_next differs from fall.
        pred_next   = exe_q.pred ? exe_q.pbt : fall;
        mispredict  = resolve & (actual_next != pred_next);

        exe_PC         = resolve ? exe_q.pc : '0;
        exe_update     = resolve & (exe_q.btype | exe_q.jump);
        exe_feedback   = exe_update & taken;
        exe_correction = mispredict;
        flush          = mispredict;
        exe_CNI        = resolve ? actual_next : '0;
    end

    // Next-state for ID and EXE: flush beats stall, stall beats advance.
    always_comb begin
        id_d  = id_q;
        exe_d = exe_q;
        if (mispredict) begin
            id_d.vld  = 1'b0;
            exe_d.vld = 1'b0;
        end else begin
            if (!exe_stall) begin
                // Copy the whole ID slot, then overlay the decode that ID produced for it.
                exe_d        = id_q;
                exe_d.btype  = id_is_btype;
                exe_d.jump   = id_is_jump;
                exe_d.comp   = id_is_comp;
                exe_d.target = id_branchtarget;
                if (id_stall) begin
                    exe_d.vld = 1'b0;
                end
            end
            if (!id_stall) begin
                id_d        = '0;
                id_d.vld    = if_valid;
                id_d.pc     = if_PC;
                id_d.pred   = if_prediction;
                id_d.pbt    = if_PBT;
            end
        end
    end

    // Stage registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (nrst) begin
            id_q  <= '0;
            exe_q <= '0;
        end else begin
            id_q  <= id_d;
            exe_q <= exe_d;
        end
    end

`ifdef BRU_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0] mp_cnt_q, mp_cnt_d;

    // Saturating counts of BHT updates and of mispredicted branches/jumps.
    always_comb begin
        br_cnt_d = br_cnt_q;
        mp_cnt_d = mp_cnt_q;
        if (exe_update && (br_cnt_q != CNT_MAX)) begin
            br_cnt_d = br_cnt_q + 1'b1;
        end
        if (exe_update && exe_correction && (mp_cnt_q != CNT_MAX)) begin
            mp_cnt_d = mp_cnt_q + 1'b1;
        end
    end

    // Counter registers, cleared by reset.
    always_ff @(posedge CLK) begin
        if (nrst) begin
            br_cnt_q <= '0;
            mp_cnt_q <= '0;
        end else begin
            br_cnt_q <= br_cnt_d;
            mp_cnt_q <= mp_cnt_d;
        end
    end

    assign perf_br_cnt = br_cnt_q;
    assign perf_mp_cnt = mp_cnt_q;
`else
    assign perf_br_cnt = '0;
    assign perf_mp_cnt = '0;
`endif

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
EXE-side counterpart of the branch history table. It carries each fetched instruction's prediction (taken bit, predicted target) from IF through ID into EXE. In EXE it resolves the real branch or jump outcome and returns the result to the BHT: the PC, the taken bit and an update strobe. On a wrong prediction it raises correction/flush and supplies the correct next instruction (CNI) address.

Parameters:
PC_W, 10, PC width in halfword units; all PC arithmetic wraps mod 2^PC_W
XLEN, 32, operand width for branch compare
CNT_W, 16, performance counter width (used only with the optional feature)

Ports:
CLK  in  1  clock
nrst  in  1  reset; synchronous, active-high (1 = reset), sampled on rising CLK
if_valid  in  1  IF holds a real instruction
if_PC  in  PC_W  IF PC
if_prediction  in  1  BHT predicted taken
if_PBT  in  PC_W  BHT predicted target
id_stall  in  1  hold ID stage
exe_stall  in  1  hold EXE stage
id_is_btype  in  1  ID instruction is a conditional branch
id_is_jump  in  1  ID instruction is JAL/JALR/C.J/C.JAL/C.JR/C.JALR
id_is_comp  in  1  ID instruction is 16-bit
id_branchtarget  in  PC_W  target computed in ID
exe_funct3  in  3  branch funct3 in EXE
exe_rs1, exe_rs2  in  XLEN  forwarded operands
exe_PC  out  PC_W  PC of resolving instruction (to BHT)
exe_update  out  1  BHT write strobe
exe_feedback  out  1  actual taken
exe_correction  out  1  misprediction
flush  out  1  squash IF/ID
exe_CNI  out  PC_W  correct next PC
perf_br_cnt, perf_mp_cnt  out  CNT_W  resolved-branch / misprediction counts

Behaviour:
- Reset: all stage valid bits 0, stage registers 0, counters 0. Every output is 0 while the EXE valid bit is 0.
- ID register: loads {if_valid, if_PC, if_prediction, if_PBT} when !id_stall; holds otherwise.
- EXE register: loads the ID contents plus the ID decode inputs when !exe_stall. If id_stall=1 and exe_stall=0, EXE loads a bubble (valid=0).
- resolve = exe_vld & !exe_stall. Each instruction resolves exactly once, in its final EXE cycle. All result outputs are qualified by resolve; they are combinational from the EXE register and operands.
- Fall-through: fall = exe_PC + (comp ? 1 : 2), wrapping.
- Taken:
  - jump → 1.
  - btype → BEQ 000 (==), BNE 001 (!=), BLT 100 (signed <), BGE 101 (signed >=), BLTU 110, BGEU 111.
  - funct3 010/011 → 0.
  - Any other instruction → 0.
- actual_next = taken ? target : fall. pred_next = pred ? PBT : fall.
- exe_correction = flush = resolve & (actual_next != pred_next). This covers wrong direction, wrong target, and a predicted-taken non-branch (alias).
- exe_CNI = actual_next when resolve, else 0.
- exe_update = resolve & (btype | jump). exe_feedback = exe_update & taken.
- Flush cycle: ID and EXE valid bits are cleared at the next edge, regardless of id_stall/exe_stall. The flushing instruction itself retires.
- Priority at a clock edge: nrst > flush > stall > advance.
- Reset asserted mid-operation: all state is lost, with no resolve in that cycle.

Optional Feature:
- Macro BRU_PERF_CNT_EN.
- Defined:
  - perf_br_cnt increments on exe_update.
  - perf_mp_cnt increments on exe_correction & exe_update.
  - Both saturate at 2^CNT_W-1 and clear on nrst.
- Undefined: both ports are tied to 0 and no flops are inferred.

Decomposition:
- Package bru_pkg: PC_W/XLEN defaults, funct3 localparams (F3_BEQ … F3_BGEU), and a packed stage typedef {vld, pc, pred, pbt, btype, jump, comp, target}.
- Sub-module branch_cmp: combinational funct3 + rs1/rs2 → taken.

Test Plan:
- BEQ at PC 0x040, not comp, rs1=rs2=5, target 0x080, pred=0, PBT=0 → resolve: update=1, feedback=1, correction=1, flush=1, CNI=0x080; next cycle ID/EXE valid=0.
- BNE at PC 0x100, rs1=rs2, pred=0 → feedback=0, correction=0, flush=0; CNI=0x102 (comp=1 → CNI=0x101).
- BLT rs1=0xFFFFFFFF, rs2=1 → taken; BLTU with the same operands → not taken. With pred=1, PBT=target, the BLTU case → correction=1, CNI=fall.
- JAL at PC 0x3FE, target 0x010, pred=1, PBT=0x020 → correction=1, CNI=0x010. Same JAL with pred=0 at PC 0x3FE, comp=0 → fall wraps to 0x000, correction=1.
- Non-branch with pred=1, PBT=0x050, PC 0x060 → update=0, correction=1, CNI=0x062. Hold exe_stall=1 for 3 cycles first → no outputs until release, then exactly one resolve. Assert id_stall with exe_stall=0 → next EXE is a bubble.
- Under BRU_PERF_CNT_EN: preload near saturation (CNT_W=4 build), issue 20 mispredicted branches → both counters stick at 15. nrst mid-stream → counters 0 and valid bits 0 next cycle.
